// File: rtl/fp_alu_pkg.sv
// Shared definitions for the sequential floating-point ALU.
// Holds the op encodings, the FSM state enum, the flag bit positions and
// the operand class encoding. Format-independent.
package fp_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SPECIAL, ST_ALIGN, ST_EXEC, ST_NORM, ST_PACK, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN
  } cls_e;

  function automatic logic is_nan(input cls_e c);
    return (c == CLS_QNAN) || (c == CLS_SNAN);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier.
// Ports: x    - packed operand {sign, exp, man}
//        cls  - zero / normal / inf / qNaN / sNaN (denormals report zero)
//        sgn  - sign bit
//        expo - biased exponent field
//        man  - mantissa with hidden bit prepended (0 for zero class)
module fp_classify
  import fp_alu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output cls_e                 cls,
  output logic                 sgn,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       man
);

  logic [MAN_W-1:0] frac;

  assign sgn  = x[EXP_W+MAN_W];
  assign expo = x[EXP_W+MAN_W-1:MAN_W];
  assign frac = x[MAN_W-1:0];

  always_comb begin
    cls = CLS_NORM;
    man = {1'b1, frac};
    if (expo == '0) begin
      // denormals flush to signed zero
      cls = CLS_ZERO;
      man = '0;
    end else if (&expo) begin
      if (frac == '0)          cls = CLS_INF;
      else if (frac[MAN_W-1])  cls = CLS_QNAN;
      else                     cls = CLS_SNAN;
    end
  end

endmodule

// File: rtl/fp_alu_seq.sv
// Multi-cycle floating-point ALU: add, sub (A-B), mul, max.
// One operation in flight; valid/ready on both sides.
// Ports: clk, rst (sync, active high)
//        in_valid/in_ready, in1, in2, op - operation request
//        out_valid/out_ready, out, flags - result {invalid, overflow, underflow}
// Rounding is truncation; denormal inputs are treated as signed zero.
module fp_alu_seq
  import fp_alu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic [2:0]           flags
);

  localparam int N    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;          // mantissa incl. hidden bit
  localparam int W    = 2 * M;              // working mantissa / product
  localparam int XW   = EXP_W + 2;          // signed working exponent
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int CW   = $clog2(M + 1);

  localparam logic signed [XW-1:0] E_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] E_BIAS = XW'(BIAS);
  localparam logic signed [XW-1:0] E_ONE  = XW'(1);
  localparam logic signed [XW-1:0] E_ZERO = '0;
  localparam logic [N-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [N-1:0] inf_w(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [N-1:0] zero_w(input logic s);
    return {s, {(N-1){1'b0}}};
  endfunction

  state_e               state;
  logic [N-1:0]         a_r, b_r;
  logic [1:0]           op_r;
  logic                 sgn_r, sub_r;
  logic signed [XW-1:0] exp_r;
  logic [M-1:0]         mx_r, my_r;
  logic [W-1:0]         wm;
  logic [CW-1:0]        cnt;

  cls_e             ca, cb;
  logic             sa, sb, sbe;
  logic [EXP_W-1:0] ea, eb;
  logic [M-1:0]     ma, mb;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x(a_r), .cls(ca), .sgn(sa), .expo(ea), .man(ma));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x(b_r), .cls(cb), .sgn(sb), .expo(eb), .man(mb));

  // magnitudes with denormals flushed, for ordering and add/sub swap
  logic [N-2:0] mag_a, mag_b;
  logic         a_ge;
  assign sbe   = sb ^ (op_r == OP_SUB);
  assign mag_a = (ca == CLS_ZERO) ? '0 : a_r[N-2:0];
  assign mag_b = (cb == CLS_ZERO) ? '0 : b_r[N-2:0];
  assign a_ge  = mag_a >= mag_b;

  assign in_ready = !rst && (state == ST_IDLE);

  // special-case short cut, resolved entirely in the SPECIAL cycle
  logic         spec_hit, spec_inv, a_wins;
  logic [N-1:0] spec_res;
  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    a_wins   = 1'b0;
    if (is_nan(ca) || is_nan(cb)) begin
      spec_res = QNAN;
      spec_inv = (ca == CLS_SNAN) || (cb == CLS_SNAN);
    end else if (op_r == OP_MAX) begin
      // positive beats negative (so +0 beats -0); among negatives the
      // smaller magnitude is the larger value
      if (sa != sb) a_wins = !sa;
      else          a_wins = sa ? (mag_a <= mag_b) : a_ge;
      if (a_wins) spec_res = (ca == CLS_ZERO) ? zero_w(sa) : a_r;
      else        spec_res = (cb == CLS_ZERO) ? zero_w(sb) : b_r;
    end else if (op_r == OP_MUL) begin
      if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
        spec_res = QNAN;
        spec_inv = 1'b1;
      end else if (ca == CLS_INF || cb == CLS_INF)   spec_res = inf_w(sa ^ sb);
      else if (ca == CLS_ZERO || cb == CLS_ZERO)     spec_res = zero_w(sa ^ sb);
      else                                           spec_hit = 1'b0;
    end else begin
      if (ca == CLS_INF && cb == CLS_INF) begin
        spec_res = (sa != sbe) ? QNAN : inf_w(sa);
        spec_inv = (sa != sbe);
      end else if (ca == CLS_INF)                     spec_res = inf_w(sa);
      else if (cb == CLS_INF)                         spec_res = inf_w(sbe);
      else if (ca == CLS_ZERO && cb == CLS_ZERO)      spec_res = zero_w(sa & sbe);
      else if (ca == CLS_ZERO)                        spec_res = {sbe, b_r[N-2:0]};
      else if (cb == CLS_ZERO)                        spec_res = {sa, a_r[N-2:0]};
      else                                            spec_hit = 1'b0;
    end
  end

  // alignment: larger magnitude stays, smaller is shifted right
  logic [EXP_W-1:0] e_big, e_diff;
  logic [M-1:0]     m_big, m_small, m_shift;
  always_comb begin
    e_big   = a_ge ? ea : eb;
    e_diff  = a_ge ? ea - eb : eb - ea;
    m_big   = a_ge ? ma : mb;
    m_small = a_ge ? mb : ma;
    m_shift = (int'(e_diff) >= M + 1) ? '0 : m_small >> e_diff;
  end

  logic [M:0] add_sum, mul_sum;
  assign add_sum = sub_r ? {1'b0, mx_r} - {1'b0, my_r} : {1'b0, mx_r} + {1'b0, my_r};
  assign mul_sum = {1'b0, wm[W-1:M]} + {1'b0, (wm[0] ? mx_r : {M{1'b0}})};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out       <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_r   <= in1;
          b_r   <= in2;
          op_r  <= op;
          state <= ST_SPECIAL;
        end
        ST_SPECIAL: if (spec_hit) begin
          out       <= spec_res;
          flags     <= {spec_inv, 2'b00};
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end else begin
          state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          if (op_r == OP_MUL) begin
            sgn_r <= sa ^ sb;
            exp_r <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - E_BIAS;
            mx_r  <= ma;
            wm    <= {{M{1'b0}}, mb};  // multiplier sits in the low half
            cnt   <= '0;
          end else begin
            sgn_r <= a_ge ? sa : sbe;
            sub_r <= sa ^ sbe;
            exp_r <= $signed({2'b00, e_big});
            mx_r  <= m_big;
            my_r  <= m_shift;
          end
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op_r == OP_MUL) begin
            // shift-add: accumulate into the high half, retire one
            // multiplier bit from the low half per cycle
            wm  <= {mul_sum, wm[M-1:1]};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(M - 1)) state <= ST_NORM;
          end else begin
            // hidden bit lands on W-2, carry on W-1, same as the product
            wm    <= {add_sum, {(M-1){1'b0}}};
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (wm[W-1]) begin
            wm    <= wm >> 1;
            exp_r <= exp_r + E_ONE;
            state <= ST_PACK;
          end else if (wm == '0 || wm[W-2]) begin
            state <= ST_PACK;
          end else begin
            wm    <= wm << 1;
            exp_r <= exp_r - E_ONE;
            if (wm[W-3]) state <= ST_PACK;
          end
        end
        ST_PACK: begin
          flags <= '0;
          if (wm == '0) begin
            out <= '0;                     // exact cancellation is +0
          end else if (exp_r >= E_MAX) begin
            out            <= inf_w(sgn_r);
            flags[FLG_OVF] <= 1'b1;
          end else if (exp_r <= E_ZERO) begin
            out            <= zero_w(sgn_r);
            flags[FLG_UNF] <= 1'b1;
          end else begin
            out <= {sgn_r, exp_r[EXP_W-1:0], wm[W-3 -: MAN_W]};
          end
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_alu_seq.sv
// Scoreboard bench for fp_alu_seq at the default single-precision format.
module tb_fp_alu_seq;
  import fp_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0, in2 = '0;
  logic [1:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic [2:0]  flags;

  fp_alu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .flags(flags));

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] res; logic [2:0] flg; int lat; } exp_t;
  typedef struct { logic [31:0] res; logic [2:0] flg; int lat; } got_t;

  exp_t sb_q[$];
  got_t got_q[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, acc_cyc = 0, first_cyc = 0, n_acc = 0;
  bit   seen_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: stamps accepts, first out_valid cycle, captures handshakes
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
        n_acc++;
        seen_ov = 1'b0;
      end
      if (out_valid && !seen_ov) begin
        seen_ov   = 1'b1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready)
        got_q.push_back('{out, flags, first_cyc - acc_cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       input logic [31:0] eo, input logic [2:0] ef, input int el,
                       input string tag);
    sb_q.push_back('{tag, eo, ef, el});
    @(posedge clk); #1;
    in1 = a; in2 = b; op = o; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    exp_t e;
    got_t g;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (got_q.size() >= sb_q.size()) break;
    end
    chk("result_count", 32'(got_q.size()), 32'(sb_q.size()));
    while (sb_q.size() > 0 && got_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      chk({e.tag, "_out"},   g.res,        e.res);
      chk({e.tag, "_flags"}, 32'(g.flg),   32'(e.flg));
      chk({e.tag, "_lat"},   32'(g.lat),   32'(e.lat));
    end
    sb_q.delete();
    got_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int saved;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out, 32'h0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // arithmetic paths
    issue(32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 3'b000, 6,  "add_1_2");   drain(100);
    issue(32'h3F800001, 32'h3F800000, OP_SUB, 32'h34000000, 3'b000, 28, "sub_k23");   drain(100);
    issue(32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 3'b000, 6,  "sub_cancel"); drain(100);
    issue(32'h3FC00000, 32'h3FC00000, OP_ADD, 32'h40400000, 3'b000, 6,  "add_carry"); drain(100);
    issue(32'h4C000000, 32'h3F800000, OP_ADD, 32'h4C000000, 3'b000, 6,  "add_far");   drain(100);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, 32'h7F800000, 3'b010, 6,  "add_ovf");   drain(100);
    issue(32'h3FC00000, 32'h40000000, OP_MUL, 32'h40400000, 3'b000, 29, "mul_1p5_2"); drain(100);
    issue(32'h7F7FFFFF, 32'h40000000, OP_MUL, 32'h7F800000, 3'b010, 29, "mul_ovf");   drain(100);
    issue(32'h00800000, 32'h00800000, OP_MUL, 32'h00000000, 3'b001, 29, "mul_unf");   drain(100);

    // special cases
    issue(32'h7F800000, 32'hFF800000, OP_ADD, 32'h7FC00000, 3'b100, 2, "inf_m_inf");  drain(50);
    issue(32'h7F800001, 32'h3F800000, OP_MUL, 32'h7FC00000, 3'b100, 2, "snan_mul");   drain(50);
    issue(32'h7FC00000, 32'h3F800000, OP_ADD, 32'h7FC00000, 3'b000, 2, "qnan_add");   drain(50);
    issue(32'h7F800000, 32'h00000000, OP_MUL, 32'h7FC00000, 3'b100, 2, "inf_x_0");    drain(50);
    issue(32'h40000000, 32'h80000000, OP_ADD, 32'h40000000, 3'b000, 2, "x_plus_0");   drain(50);
    issue(32'h80000000, 32'h00000000, OP_SUB, 32'h80000000, 3'b000, 2, "m0_minus_0"); drain(50);
    issue(32'h80000000, 32'h00000000, OP_MAX, 32'h00000000, 3'b000, 2, "max_zeros");  drain(50);
    issue(32'h3F800000, 32'hC0000000, OP_MAX, 32'h3F800000, 3'b000, 2, "max_mixed");  drain(50);
    issue(32'hBF800000, 32'hC0000000, OP_MAX, 32'hBF800000, 3'b000, 2, "max_neg");    drain(50);

    // backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 3'b000, 6, "bp_add");
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    saved = n_acc;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      in1 = 32'h3F800000; in2 = 32'h3F800000; op = OP_MUL;
      @(negedge clk);
      chk("bp_out", out, 32'h40400000);
      chk("bp_flags", 32'(flags), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_no_accept", 32'(n_acc), 32'(saved + 0));
    drain(20);

    // back-to-back: second request waits on in_ready
    issue(32'h3FC00000, 32'h40000000, OP_MUL, 32'h40400000, 3'b000, 29, "b2b_mul");
    issue(32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 3'b000, 6,  "b2b_add");
    drain(100);

    // reset mid-multiply
    issue(32'h3FC00000, 32'h40000000, OP_MUL, 32'h40400000, 3'b000, 29, "rst_mul");
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", out, 32'h0);
    chk("midrst_flags", 32'(flags), 32'd0);
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clk);
    chk("midrst_no_result", 32'(got_q.size()), 32'd0);
    got_q.delete();
    issue(32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 3'b000, 6, "post_rst_add");
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
